// File: rtl/clk_gate_ctrl.sv
// Idle-driven enable controller for N clock-gate cells: per-domain OFF/WAKE/ON/HOLD
// FSMs, a round-robin wake arbiter with minimum grant spacing, and a scan force-on.
module clk_gate_ctrl #(
  parameter int N        = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic         CK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic         FORCE_ON,
  output logic [N-1:0] E,
  output logic [N-1:0] ACK,
  output logic         BUSY
);

  localparam int CMAX = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = $clog2(GAP_CYC + 1);
  localparam int PW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } dom_state_e;

  dom_state_e    state_q [N];
  dom_state_e    state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  e_q, e_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  e_fsm;
  logic [N-1:0]  eligible;
  logic [N-1:0]  grant_oh;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic          busy;

  // Position 'off' steps after 'base' on the ring; both operands are below N.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (int'(idx) == N - 1) return '0;
    return idx + PW'(1);
  endfunction

  // Wake arbiter: scanned from the far end so the entry nearest ptr wins.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = (state_q[i] == ST_OFF) && REQ[i];
    end
    grant_vld = 1'b0;
    grant_idx = '0;
    if (gap_q == '0) begin
      for (int off = N - 1; off >= 0; off--) begin
        if (eligible[rr_index(ptr_q, off)]) begin
          grant_vld = 1'b1;
          grant_idx = rr_index(ptr_q, off);
        end
      end
    end
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    gap_d = gap_q;
    ptr_d = ptr_q;
    if (grant_vld) begin
      gap_d = GAP_LOAD;
      ptr_d = next_ptr(grant_idx);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (grant_oh[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == '0) state_d[i] = ST_ON;
          else                cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        ST_ON: begin
          if (!REQ[i]) begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = IDLE_LOAD;
          end
        end
        ST_HOLD: begin
          if (REQ[i])              state_d[i] = ST_ON;
          else if (cnt_q[i] == '0) state_d[i] = ST_OFF;
          else                     cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        default: state_d[i] = ST_OFF;
      endcase
      e_fsm[i] = (state_d[i] != ST_OFF);
      ack_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
    end
    e_d = FORCE_ON ? '1 : e_fsm;
  end

  // State register stage: E and ACK are registered from next-state so they
  // change on the same edge as the FSM.
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      gap_q <= '0;
      ptr_q <= '0;
      e_q   <= '0;
      ack_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gap_q <= gap_d;
      ptr_q <= ptr_d;
      e_q   <= e_d;
      ack_q <= ack_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (state_q[i] != ST_OFF) busy = 1'b1;
    end
  end

  assign E    = e_q;
  assign ACK  = ack_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Vector-table bench for clk_gate_ctrl (N=4, IDLE=16, WAKE=2, GAP=4); expected
// outputs are queued when each vector is driven and compared after its edge.
module tb_clk_gate_ctrl;

  logic       ck = 1'b0;
  logic       rst;
  logic       fo;
  logic [3:0] req;
  logic [3:0] e;
  logic [3:0] ack;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cur_sec = 0;

  always #5 ck = ~ck;

  clk_gate_ctrl #(
    .N(4), .IDLE_CYC(16), .WAKE_CYC(2), .GAP_CYC(4)
  ) dut (
    .CK(ck), .RST(rst), .REQ(req), .FORCE_ON(fo),
    .E(e), .ACK(ack), .BUSY(busy)
  );

  typedef struct {
    int         sec;
    logic       rst;
    logic [3:0] req;
    logic       fo;
    logic [3:0] e;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  typedef struct {
    int         sec;
    int         idx;
    logic [3:0] e;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input int n, input logic r, input logic [3:0] q, input logic f,
                     input logic [3:0] xe, input logic [3:0] xa, input logic xb);
    vec_t v;
    v.sec = cur_sec; v.rst = r; v.req = q; v.fo = f;
    v.e = xe; v.ack = xa; v.busy = xb;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int sec, input int idx,
                     input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s sec%0d vec%0d: got %b want %b", name, sec, idx, got, want);
    end
  endtask

  initial begin
    vec_t v;
    exp_t ex;
    logic [3:0] xe;
    logic [3:0] xa;

    rst = 1'b1; req = '0; fo = 1'b0;

    // reset, then single request, idle drop-out after 16 idle edges
    cur_sec = 1;
    add(2, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(2, 0, 4'b0001, 0, 4'b0001, 4'b0000, 1);
    add(2, 0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    add(16, 0, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    add(2, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    // re-wake, then REQ returns 10 edges into HOLD: ACK never falls
    cur_sec = 3;
    add(2, 0, 4'b0001, 0, 4'b0001, 4'b0000, 1);
    add(2, 0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    add(10, 0, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    add(8, 0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    add(16, 0, 4'b0000, 0, 4'b0001, 4'b0001, 1);
    add(2, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    // all four request: grants at edges 1,5,9,13, ACK at 3,7,11,15
    cur_sec = 2;
    add(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    for (int t = 1; t <= 17; t++) begin
      xe = '0; xa = '0;
      for (int i = 0; i < 4; i++) begin
        if (t >= 1 + 4 * i) xe[i] = 1'b1;
        if (t >= 3 + 4 * i) xa[i] = 1'b1;
      end
      add(1, 0, 4'b1111, 0, xe, xa, 1);
    end

    // round-robin after grant to 2: domain 3 before domain 0
    cur_sec = 4;
    add(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 0, 4'b0100, 0, 4'b0100, 4'b0000, 1);
    add(1, 0, 4'b1101, 0, 4'b0100, 4'b0000, 1);
    add(2, 0, 4'b1101, 0, 4'b0100, 4'b0100, 1);
    add(2, 0, 4'b1101, 0, 4'b1100, 4'b0100, 1);
    add(2, 0, 4'b1101, 0, 4'b1100, 4'b1100, 1);
    add(2, 0, 4'b1101, 0, 4'b1101, 4'b1100, 1);
    add(2, 0, 4'b1101, 0, 4'b1101, 4'b1101, 1);

    // request withdrawn before grant: domain 1 skipped, 2 then 3 granted
    cur_sec = 7;
    add(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 0, 4'b1111, 0, 4'b0001, 4'b0000, 1);
    add(1, 0, 4'b1101, 0, 4'b0001, 4'b0000, 1);
    add(2, 0, 4'b1101, 0, 4'b0001, 4'b0001, 1);
    add(2, 0, 4'b1101, 0, 4'b0101, 4'b0001, 1);
    add(2, 0, 4'b1101, 0, 4'b0101, 4'b0101, 1);
    add(2, 0, 4'b1101, 0, 4'b1101, 4'b0101, 1);
    add(1, 0, 4'b1101, 0, 4'b1101, 4'b1101, 1);

    // reset during domain 1 WAKE, then pointer restarts at 0
    cur_sec = 5;
    add(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(2, 0, 4'b0011, 0, 4'b0001, 4'b0000, 1);
    add(2, 0, 4'b0011, 0, 4'b0001, 4'b0001, 1);
    add(1, 0, 4'b0011, 0, 4'b0011, 4'b0001, 1);
    add(1, 1, 4'b0011, 0, 4'b0000, 4'b0000, 0);
    add(2, 0, 4'b1111, 0, 4'b0001, 4'b0000, 1);
    add(1, 0, 4'b1111, 0, 4'b0001, 4'b0001, 1);

    // force-on: ignored under reset, all E high while idle, released next edge
    cur_sec = 6;
    add(1, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0);
    add(3, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0);
    add(2, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge ck);
      v = vecs[i];
      rst = v.rst; req = v.req; fo = v.fo;
      ex.sec = v.sec; ex.idx = i; ex.e = v.e; ex.ack = v.ack; ex.busy = v.busy;
      sb.push_back(ex);
      @(posedge ck);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard vec%0d: got empty queue want entry", i);
      end else begin
        ex = sb.pop_front();
        chk("E",    ex.sec, ex.idx, e,    ex.e);
        chk("ACK",  ex.sec, ex.idx, ack,  ex.ack);
        chk("BUSY", ex.sec, ex.idx, {3'b000, busy}, {3'b000, ex.busy});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
